// File: rtl/crossbar_arbiter_if.sv
// Request/grant handshake bundle between the TileLink masters, the crossbar and crossbar_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/crossbar side.
interface crossbar_arbiter_if #(
  parameter int NUM_MASTERS = 16,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) ();
  logic [NUM_MASTERS-1:0] request;
  logic                   xfer_done;
  logic [NUM_MASTERS-1:0] grant;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   timeout_err;
  logic [ID_W-1:0]        timeout_id;

  modport master (
    output request,
    output xfer_done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout_err,
    input  timeout_id
  );

  modport slave (
    input  request,
    input  xfer_done,
    output grant,
    output grant_id,
    output busy,
    output timeout_err,
    output timeout_id
  );
endinterface

// File: rtl/crossbar_arbiter.sv
// Round-robin crossbar arbiter: one grant at a time, held until xfer_done, then one dead cycle.
// Optional grant watchdog is built only when ARB_TIMEOUT_EN is defined.
module crossbar_arbiter #(
  parameter int NUM_MASTERS = 16,
  parameter int TIMEOUT     = 1024,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input logic            clk,
  input logic            rst,
  crossbar_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("crossbar_arbiter: TIMEOUT must be at least 1");
  end

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;

  logic                   pick_valid_s;
  logic [ID_W-1:0]        pick_id_s;
  logic [ID_W-1:0]        idx_s;
  logic [ID_W-1:0]        next_ptr_s;
  logic                   timeout_hit_s;

  // Round-robin pick: scan from lowest to highest priority so the nearest set bit at or after rr_ptr wins last.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = '0;
    idx_s        = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx_s        = ID_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
      pick_id_s    = bus.request[idx_s] ? idx_s : pick_id_s;
      pick_valid_s = pick_valid_s | bus.request[idx_s];
    end
  end

  assign next_ptr_s = (grant_id_q == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id_q + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]  timeout_id_q, timeout_id_d;
  logic             timeout_fire_s;

  // The current BUSY cycle is the TIMEOUT-th one when the counter still reads TIMEOUT-1.
  assign timeout_hit_s  = (wd_cnt_q == CNT_W'(TIMEOUT - 1));
  assign timeout_fire_s = (state_q == ST_BUSY) && !bus.xfer_done && timeout_hit_s;

  // Watchdog next-state: counts BUSY cycles, zero everywhere else, so entry to BUSY starts at zero.
  always_comb begin
    wd_cnt_d      = (state_q == ST_BUSY) ? wd_cnt_q + CNT_W'(1) : '0;
    timeout_err_d = timeout_fire_s;
    timeout_id_d  = timeout_fire_s ? grant_id_q : timeout_id_q;
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
  assign bus.timeout_id  = timeout_id_q;
`else
  assign timeout_hit_s   = 1'b0;
  assign bus.timeout_err = 1'b0;
  assign bus.timeout_id  = '0;
`endif

  // Arbiter FSM next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d    = ST_BUSY;
          grant_d    = NUM_MASTERS'(1) << pick_id_s;
          grant_id_d = pick_id_s;
          busy_d     = 1'b1;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        // xfer_done takes precedence over a watchdog expiry in the same cycle.
        if (bus.xfer_done || timeout_hit_s) begin
          state_d  = ST_RELEASE;
          rr_ptr_d = next_ptr_s;
          grant_d  = '0;
          busy_d   = 1'b0;
        end else begin
          grant_d = grant_q;
          busy_d  = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule
